// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and
// E-stage operand forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'b00,
    RUN       = 2'b01,
    MD_BUSY   = 2'b10,
    MEM_WAIT  = 2'b11
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // A load in E whose destination feeds either source of the instruction in D.
  function automatic logic load_use_hit(input logic       mem_read_e,
                                        input logic [4:0] rd_e,
                                        input logic [4:0] rs1_d,
                                        input logic [4:0] rs2_d);
    return mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one E-stage source register; combinational,
// zero latency. The younger M-stage result wins over W; x0 never forwards.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if ((rs_e != 5'd0) && reg_write_m && (rd_m == rs_e)) begin
      fwd_sel = FWD_M;
    end else if ((rs_e != 5'd0) && reg_write_w && (rd_w == rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencer for a 5-stage pipeline. Outputs are combinational
// from registered state plus current inputs; multi-cycle events hold upstream stages.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT      = 4,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemRead_E,
  input  logic       PCSrc_E,
  input  logic       MdStart_E,
  input  logic       DMemReq_M,
  input  logic       DMemReady_M,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Stall_M,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       Flush_W,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       MdDone_E,
  output logic       MemTimeout
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);
  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  hz_state_t      state_q, state_d;
  logic [3:0]     md_cnt_q, md_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_timeout_q, mem_timeout_d;

  fwd_sel_t fwd_a, fwd_b;
  logic     mem_stall, lw_stall, run_eval;

  forward_unit u_fwd_a (
    .rs_e        (Rs1_E),
    .rd_m        (Rd_M),
    .rd_w        (Rd_W),
    .reg_write_m (RegWrite_M),
    .reg_write_w (RegWrite_W),
    .fwd_sel     (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (Rs2_E),
    .rd_m        (Rd_M),
    .rd_w        (Rd_W),
    .reg_write_m (RegWrite_M),
    .reg_write_w (RegWrite_W),
    .fwd_sel     (fwd_b)
  );

  assign mem_stall  = DMemReq_M && !DMemReady_M;
  assign lw_stall   = load_use_hit(MemRead_E, Rd_E, Rs1_D, Rs2_D);
  assign MemTimeout = mem_timeout_q;

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    run_eval      = 1'b0;
    Stall_F       = 1'b0;
    Stall_D       = 1'b0;
    Stall_E       = 1'b0;
    Stall_M       = 1'b0;
    Flush_D       = 1'b0;
    Flush_E       = 1'b0;
    Flush_W       = 1'b0;
    MdDone_E      = 1'b0;
    ForwardA_E    = fwd_a;
    ForwardB_E    = fwd_b;

    unique case (state_q)
      RST_FLUSH: begin
        Flush_D    = 1'b1;
        Flush_E    = 1'b1;
        Flush_W    = 1'b1;
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        state_d    = RUN;
      end
      RUN: run_eval = 1'b1;
      MD_BUSY: begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        // A memory stall freezes the mul/div countdown along with M.
        if (mem_stall) begin
          Stall_M = 1'b1;
        end else if (md_cnt_q == 4'd1) begin
          MdDone_E = 1'b1;
          md_cnt_d = 4'd0;
          state_d  = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      MEM_WAIT: begin
        if (DMemReady_M) begin
          run_eval = 1'b1;
        end else begin
          Stall_F    = 1'b1;
          Stall_D    = 1'b1;
          Stall_E    = 1'b1;
          Stall_M    = 1'b1;
          Flush_W    = 1'b1;
          wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
          if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
        end
      end
      default: state_d = RST_FLUSH;
    endcase

    // Free-running decision; also used on the cycle a memory wait completes.
    if (run_eval) begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (mem_stall) begin
        Stall_F    = 1'b1;
        Stall_D    = 1'b1;
        Stall_E    = 1'b1;
        Stall_M    = 1'b1;
        Flush_W    = 1'b1;
        wait_cnt_d = WCW'(1);
        state_d    = MEM_WAIT;
      end else if (MdStart_E) begin
        Stall_F  = 1'b1;
        Stall_D  = 1'b1;
        md_cnt_d = MD_LOAD;
        state_d  = MD_BUSY;
      end else if (PCSrc_E) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (lw_stall) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= RST_FLUSH;
      md_cnt_q      <= 4'd0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: a driver issues directed and
// random cycles and queues expected outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

  localparam int MD_LAT      = 4;
  localparam int MEM_TIMEOUT = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_m, regwrite_w, memread_e, pcsrc_e, mdstart_e;
    logic       dmemreq_m, dmemready_m;
  } stim_t;

  // stall = {F,D,E,M}, flush = {D,E,W}
  typedef struct packed {
    logic [3:0] stall;
    logic [2:0] flush;
    logic [1:0] fa, fb;
    logic       done, timeout;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] Rs1_D = '0, Rs2_D = '0, Rs1_E = '0, Rs2_E = '0;
  logic [4:0] Rd_E = '0, Rd_M = '0, Rd_W = '0;
  logic       RegWrite_M = 1'b0, RegWrite_W = 1'b0, MemRead_E = 1'b0;
  logic       PCSrc_E = 1'b0, MdStart_E = 1'b0, DMemReq_M = 1'b0, DMemReady_M = 1'b1;
  logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       MdDone_E, MemTimeout;

  pipeline_hazard_controller #(.MD_LAT(MD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .MemRead_E(MemRead_E),
    .PCSrc_E(PCSrc_E), .MdStart_E(MdStart_E), .DMemReq_M(DMemReq_M), .DMemReady_M(DMemReady_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .MdDone_E(MdDone_E), .MemTimeout(MemTimeout)
  );

  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: pipeline situation described as pending work.
  bit known      = 0;  // model state is meaningful once a reset edge has been seen
  bit m_bubble   = 0;  // first cycle after reset inserts a bubble everywhere
  int m_md_left  = 0;  // mul/div cycles still to run after the start cycle
  bit m_mem_wait = 0;  // waiting for data memory
  int m_waits    = 0;  // consecutive memory wait cycles seen
  bit m_tmo      = 0;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wm, input logic [4:0] rdw, input logic ww);
    if (rs == 5'd0) return 2'b00;
    if (wm && rdm == rs) return 2'b10;
    if (ww && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_step(input stim_t s);
    exp_t e = '0;
    bit mem_stall, lw, run;
    mem_stall = s.dmemreq_m && !s.dmemready_m;
    lw = s.memread_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
    e.timeout = m_tmo;
    if (!m_bubble) begin
      e.fa = fwd_ref(s.rs1_e, s.rd_m, s.regwrite_m, s.rd_w, s.regwrite_w);
      e.fb = fwd_ref(s.rs2_e, s.rd_m, s.regwrite_m, s.rd_w, s.regwrite_w);
    end
    run = 0;
    if (m_bubble) begin
      e.flush  = 3'b111;
      m_bubble = 0;
    end else if (m_mem_wait) begin
      if (s.dmemready_m) begin
        m_mem_wait = 0;
        run = 1;
      end else begin
        e.stall = 4'b1111;
        e.flush = 3'b001;
        if (m_waits < MEM_TIMEOUT) m_waits++;
        if (m_waits == MEM_TIMEOUT) m_tmo = 1;
      end
    end else if (m_md_left > 0) begin
      e.stall = mem_stall ? 4'b1111 : 4'b1110;
      if (!mem_stall) begin
        if (m_md_left == 1) e.done = 1;
        m_md_left--;
      end
    end else begin
      run = 1;
    end
    if (run) begin
      m_waits = 0;
      if (mem_stall) begin
        e.stall = 4'b1111; e.flush = 3'b001; m_mem_wait = 1; m_waits = 1;
      end else if (s.mdstart_e) begin
        e.stall = 4'b1100; m_md_left = MD_LAT - 1;
      end else if (s.pcsrc_e) begin
        e.flush = 3'b110;
      end else if (lw) begin
        e.stall = 4'b1100; e.flush = 3'b010;
      end
    end
    if (!s.rst_n) begin
      m_bubble = 1; m_md_left = 0; m_mem_wait = 0; m_waits = 0; m_tmo = 0;
    end
    return e;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit   was_known;
    @(posedge CLK);
    #1;
    cyc++;
    RST_N = s.rst_n;
    Rs1_D = s.rs1_d; Rs2_D = s.rs2_d; Rs1_E = s.rs1_e; Rs2_E = s.rs2_e;
    Rd_E = s.rd_e; Rd_M = s.rd_m; Rd_W = s.rd_w;
    RegWrite_M = s.regwrite_m; RegWrite_W = s.regwrite_w; MemRead_E = s.memread_e;
    PCSrc_E = s.pcsrc_e; MdStart_E = s.mdstart_e;
    DMemReq_M = s.dmemreq_m; DMemReady_M = s.dmemready_m;
    was_known = known;
    e = model_step(s);
    if (was_known) sb.push_back(e);
    if (!s.rst_n) known = 1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n       = ($urandom_range(0, 249) != 0);
    s.rs1_d       = 5'($urandom_range(0, 7));
    s.rs2_d       = 5'($urandom_range(0, 7));
    s.rs1_e       = 5'($urandom_range(0, 7));
    s.rs2_e       = 5'($urandom_range(0, 7));
    s.rd_e        = 5'($urandom_range(0, 7));
    s.rd_m        = 5'($urandom_range(0, 7));
    s.rd_w        = 5'($urandom_range(0, 7));
    s.regwrite_m  = 1'($urandom_range(0, 1));
    s.regwrite_w  = 1'($urandom_range(0, 1));
    s.memread_e   = ($urandom_range(0, 2) == 0);
    s.pcsrc_e     = ($urandom_range(0, 11) == 0);
    s.mdstart_e   = !s.pcsrc_e && ($urandom_range(0, 15) == 0);
    s.dmemreq_m   = ($urandom_range(0, 2) == 0);
    s.dmemready_m = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  always @(posedge CLK) begin
    if (RST_N) assert (!(PCSrc_E && MdStart_E)) else $error("illegal PCSrc_E with MdStart_E");
  end

  always @(negedge CLK) begin
    exp_t act, exp_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      act = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
             ForwardA_E, ForwardB_E, MdDone_E, MemTimeout};
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL cycle%0d outputs: got stall=%b flush=%b fa=%b fb=%b done=%b tmo=%b, want stall=%b flush=%b fa=%b fb=%b done=%b tmo=%b",
                 cyc, act.stall, act.flush, act.fa, act.fb, act.done, act.timeout,
                 exp_v.stall, exp_v.flush, exp_v.fa, exp_v.fb, exp_v.done, exp_v.timeout);
      end
    end
  end

  initial begin
    stim_t idle, s;
    idle = '0;
    idle.rst_n = 1'b1;
    idle.dmemready_m = 1'b1;

    // Reset held three cycles, then bubble and quiet RUN.
    s = idle; s.rst_n = 1'b0;
    repeat (3) drive(s);
    repeat (3) drive(idle);

    // Forwarding: M beats W, x0 never forwards, W-only path.
    s = idle; s.rs1_e = 5; s.rd_m = 5; s.regwrite_m = 1; s.rd_w = 5; s.regwrite_w = 1;
    s.rs2_e = 0;
    drive(s);
    s.regwrite_m = 0; s.rs2_e = 5;
    drive(s);
    s.rd_m = 0; s.regwrite_m = 1; s.rs1_e = 0;
    drive(s);
    drive(idle);

    // Load-use bubble.
    s = idle; s.memread_e = 1; s.rd_e = 7; s.rs2_d = 7;
    drive(s);
    drive(idle);

    // Taken branch.
    s = idle; s.pcsrc_e = 1;
    drive(s);
    drive(idle);

    // Mul/div occupancy.
    s = idle; s.mdstart_e = 1;
    drive(s);
    repeat (5) drive(idle);

    // Mul/div with a memory stall in the middle; branch during busy is ignored.
    s = idle; s.mdstart_e = 1;
    drive(s);
    s = idle; s.dmemreq_m = 1; s.dmemready_m = 0;
    repeat (2) drive(s);
    s = idle; s.pcsrc_e = 1;
    drive(s);
    repeat (4) drive(idle);

    // Memory wait long enough to time out, then release and reset.
    s = idle; s.dmemreq_m = 1; s.dmemready_m = 0;
    repeat (6) drive(s);
    s.dmemready_m = 1;
    drive(s);
    repeat (3) drive(idle);
    s = idle; s.rst_n = 0;
    drive(s);
    repeat (2) drive(idle);

    // Reset abandoning a mul/div.
    s = idle; s.mdstart_e = 1;
    drive(s);
    drive(idle);
    s = idle; s.rst_n = 0;
    drive(s);
    repeat (2) drive(idle);

    repeat (3000) drive(rand_stim());
    drive(idle);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
    @(negedge CLK);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
